alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports r0_req / r1_req  input  1  each requester's request, held until its done pulse.
REQ-005 SHALL have ports r0_a, r0_b / r1_a, r1_b  input  32  operands, stable while the matching req is high.
REQ-006 SHALL have ports r0_aluc / r1_aluc  input  4  ALU opcode, stable while the matching req is high.
REQ-007 SHALL have ports r0_done / r1_done  output  1  one-cycle pulse: result for that requester valid on res_s/res_z.
REQ-008 SHALL have ports alu_a, alu_b  output  32  and alu_aluc  output  4  driving the shared combinational ALU.
REQ-009 SHALL have ports alu_s  input  32  and alu_z  input  1  returned by the shared ALU.
REQ-010 SHALL have ports res_s  output  32  and res_z  output  1  registered result of the last completed operation.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port last_id  output  1  id of the last granted requester (round-robin pointer).

Function
REQ-013 SHALL implement FSM with states IDLE, EXEC, DONE.
REQ-014 IDLE: if any req is high, SHALL select a winner, latch its a, b and aluc into operand registers, record its id, and go to EXEC; otherwise stay in IDLE.
REQ-015 Round-robin (FIXED_PRIO=0): with both requests high, the winner SHALL be the requester that is not last_id; with one request high, that requester wins.
REQ-016 FIXED_PRIO=1: requester 0 SHALL win whenever r0_req is high.
REQ-017 last_id SHALL update to the winner's id in the same cycle its operands are latched.
REQ-018 EXEC: alu_a/alu_b/alu_aluc SHALL be driven from the operand registers only; at the clock edge, alu_s/alu_z SHALL be captured into res_s/res_z, and the FSM SHALL go to DONE.
REQ-019 DONE: rN_done SHALL be high for the recorded id only, for exactly one cycle; the other done SHALL stay 0.
REQ-020 DONE SHALL perform arbitration as in IDLE (REQ-014..017), going to EXEC if any req is high, else to IDLE.
REQ-021 A requester still holding req during its DONE cycle SHALL be treated as issuing a new request.
REQ-022 Latency SHALL be: req sampled at edge N, done high in cycle N+2; a single requester sees sustained throughput of one operation per 2 cycles.
REQ-023 Under contention with FIXED_PRIO=0, the two requesters SHALL alternate, and neither SHALL wait more than one operation.
REQ-024 In IDLE and DONE, alu_a, alu_b and alu_aluc SHALL hold the operand-register values and SHALL NOT follow requester inputs combinationally.
REQ-025 Changes to a requester's inputs after its operands are latched SHALL NOT affect its result.
REQ-026 res_s/res_z SHALL hold their value until the next EXEC capture.
REQ-027 Requests dropped before being granted SHALL be ignored, with no done pulse issued.

Reset
REQ-028 On reset assertion, regardless of clock, the block SHALL enter IDLE with: r0_done=0, r1_done=0, busy=0, last_id=1 (so requester 0 wins the first tie), res_s=0, res_z=0, operand registers=0, alu_aluc=0.
REQ-029 Reset asserted mid-operation (EXEC or DONE) SHALL abort the operation without issuing a done pulse.
REQ-030 After reset deasserts, the first arbitration SHALL happen at the first rising edge.

Verification
REQ-031 Single op: r0_req=1, a=5, b=3, aluc=0000 -> r0_done pulses 2 cycles later; res_s=8, res_z=0; r1_done=0.
REQ-032 Zero flag: r1_req=1, a=7, b=7, aluc=0100 -> r1_done pulses; res_s=0, res_z=1; last_id=1.
REQ-033 Contention, round-robin: r0_req and r1_req held high from reset -> done order r0, r1, r0, r1, one done every 2 cycles; busy stays high.
REQ-034 Contention with FIXED_PRIO=1, both requests held -> only r0_done pulses while r0_req is high; r1 is served in the DONE cycle after r0_req drops.
REQ-035 Operand isolation: r0 aluc=0110, b=0x0000ABCD; change b to 0xFFFF0000 one cycle after grant -> res_s=0xABCD0000.
REQ-036 Reset during EXEC -> no done pulse, busy=0 immediately, res_s=0; a new request afterwards completes normally.

Source files
------------

// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter in front of one shared combinational ALU.
// A request is granted, its operands are latched, the ALU result is captured
// on the following edge, and the winner gets a one-cycle done pulse.
//
// Handshake: rN_req is a level that the requester holds until rN_done.
// Operands and opcode must be stable while rN_req is high. rN_done is a
// one-cycle pulse, and res_s/res_z carry that requester's result in the same
// cycle. A req still high in its own done cycle counts as a new request.
module alu_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [3:0]  r0_aluc,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [3:0]  r1_aluc,
    output logic        r1_done,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_s,
    input  logic        alu_z,
    output logic [31:0] res_s,
    output logic        res_z,
    output logic        busy,
    output logic        last_id,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_aluc;
    logic        cur_id;
    logic        any_req;
    logic        win;
    logic        arb_en;

    // Pick the winner among the currently raised requests.
    always_comb begin
        any_req = r0_req | r1_req;
        win     = 1'b0;
        if (FIXED_PRIO != 0) begin
            win = ~r0_req;
        end else if (r0_req && r1_req) begin
            win = ~last_id;
        end else begin
            win = r1_req;
        end
    end

    // Arbitration is allowed both from IDLE and in the DONE cycle, so
    // back-to-back operations cost two cycles each.
    assign arb_en = (state == S_IDLE) || (state == S_DONE);

    // Control FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: state <= any_req ? S_EXEC : S_IDLE;
                S_EXEC:         state <= S_DONE;
                default:        state <= S_IDLE;
            endcase
        end
    end

    // Latch the winner's operands and id at grant time.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_aluc <= 4'd0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
        end else if (arb_en && any_req) begin
            op_a    <= win ? r1_a : r0_a;
            op_b    <= win ? r1_b : r0_b;
            op_aluc <= win ? r1_aluc : r0_aluc;
            cur_id  <= win;
            last_id <= win;
        end
    end

    // Capture the shared ALU output at the end of the EXEC cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_s <= 32'd0;
            res_z <= 1'b0;
        end else if (state == S_EXEC) begin
            res_s <= alu_s;
            res_z <= alu_z;
        end
    end

    // The ALU sees only the operand registers, never the live requester inputs.
    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_aluc  = op_aluc;
    assign r0_done   = (state == S_DONE) && !cur_id;
    assign r1_done   = (state == S_DONE) && cur_id;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: drives a round-robin and a fixed-priority alu_arb from the same
// requester inputs, supplies each one its own shared ALU, and compares every
// cycle against a transaction-level model of the arbiter.
module tb_alu_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r1_req;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]  r0_aluc, r1_aluc;

    logic        rr_r0_done, rr_r1_done, rr_alu_z, rr_res_z, rr_busy, rr_last_id;
    logic [31:0] rr_alu_a, rr_alu_b, rr_alu_s, rr_res_s;
    logic [3:0]  rr_alu_aluc;
    logic [1:0]  rr_dbg_state;
    logic        fp_r0_done, fp_r1_done, fp_alu_z, fp_res_z, fp_busy, fp_last_id;
    logic [31:0] fp_alu_a, fp_alu_b, fp_alu_s, fp_res_s;
    logic [3:0]  fp_alu_aluc;
    logic [1:0]  fp_dbg_state;

    int total = 0;
    int bad = 0;

    // Reference ALU used both as the shared ALU and by the model.
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'd0:    r = a + b;
            4'd1:    r = a & b;
            4'd2:    r = a | b;
            4'd3:    r = a ^ b;
            4'd4:    r = a - b;
            4'd5:    r = {31'd0, $signed(a) < $signed(b)};
            4'd6:    r = {b[15:0], 16'h0000};
            4'd7:    r = ~(a | b);
            4'd8:    r = b << a[4:0];
            4'd9:    r = b >> a[4:0];
            4'd10:   r = $signed(b) >>> a[4:0];
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign rr_alu_s = alu_f(rr_alu_a, rr_alu_b, rr_alu_aluc);
    assign rr_alu_z = (rr_alu_s == 32'd0);
    assign fp_alu_s = alu_f(fp_alu_a, fp_alu_b, fp_alu_aluc);
    assign fp_alu_z = (fp_alu_s == 32'd0);

    alu_arb #(.FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_aluc(r0_aluc), .r0_done(rr_r0_done),
        .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_aluc(r1_aluc), .r1_done(rr_r1_done),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_aluc(rr_alu_aluc),
        .alu_s(rr_alu_s), .alu_z(rr_alu_z),
        .res_s(rr_res_s), .res_z(rr_res_z), .busy(rr_busy), .last_id(rr_last_id),
        .dbg_state(rr_dbg_state)
    );

    alu_arb #(.FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_a(r0_a), .r0_b(r0_b), .r0_aluc(r0_aluc), .r0_done(fp_r0_done),
        .r1_req(r1_req), .r1_a(r1_a), .r1_b(r1_b), .r1_aluc(r1_aluc), .r1_done(fp_r1_done),
        .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_aluc(fp_alu_aluc),
        .alu_s(fp_alu_s), .alu_z(fp_alu_z),
        .res_s(fp_res_s), .res_z(fp_res_z), .busy(fp_busy), .last_id(fp_last_id),
        .dbg_state(fp_dbg_state)
    );

    // Clock / reset block.
    always #5 clock = ~clock;

    // ---------------- Reference model (index 0 = round-robin, 1 = fixed) ----
    // An operation granted at one edge is captured at the next edge and its
    // done shows in the cycle after that; any edge not directly following a
    // grant is an arbitration edge.
    bit          m_exec[2];
    bit          m_done[2];
    bit          m_id[2];
    bit          m_last[2];
    logic [31:0] m_opa[2], m_opb[2], m_res_s[2];
    logic [3:0]  m_opc[2];
    bit          m_res_z[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_exec[k] = 0; m_done[k] = 0; m_id[k] = 0; m_last[k] = 1;
            m_opa[k] = 0; m_opb[k] = 0; m_opc[k] = 0;
            m_res_s[k] = 0; m_res_z[k] = 0;
        end
    endtask

    function automatic bit pick(int k);
        if (k == 1) return r0_req ? 1'b0 : 1'b1;
        if (r0_req && r1_req) return ~m_last[k];
        return r1_req;
    endfunction

    task automatic model_edge();
        bit w;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_exec[k]) begin
                m_res_s[k] = alu_f(m_opa[k], m_opb[k], m_opc[k]);
                m_res_z[k] = (m_res_s[k] == 32'd0);
                m_exec[k] = 0;
                m_done[k] = 1;
            end else begin
                m_done[k] = 0;
                if (r0_req || r1_req) begin
                    w = pick(k);
                    m_opa[k] = w ? r1_a : r0_a;
                    m_opb[k] = w ? r1_b : r0_b;
                    m_opc[k] = w ? r1_aluc : r0_aluc;
                    m_id[k] = w;
                    m_last[k] = w;
                    m_exec[k] = 1;
                end
            end
        end
    endtask

    // ---------------- Scoreboard ------------------------------------------
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_inst(string p, int k, logic d0, logic d1, logic b, logic lid,
                              logic [31:0] rs, logic rz, logic [31:0] aa, logic [31:0] ab,
                              logic [3:0] ac);
        check({p, "_r0_done"}, 32'(d0), 32'(m_done[k] && !m_id[k]));
        check({p, "_r1_done"}, 32'(d1), 32'(m_done[k] && m_id[k]));
        check({p, "_busy"}, 32'(b), 32'(m_exec[k] || m_done[k]));
        check({p, "_last_id"}, 32'(lid), 32'(m_last[k]));
        check({p, "_res_s"}, rs, m_res_s[k]);
        check({p, "_res_z"}, 32'(rz), 32'(m_res_z[k]));
        check({p, "_alu_a"}, aa, m_opa[k]);
        check({p, "_alu_b"}, ab, m_opb[k]);
        check({p, "_alu_aluc"}, 32'(ac), 32'(m_opc[k]));
    endtask

    task automatic check_all();
        check_inst("rr", 0, rr_r0_done, rr_r1_done, rr_busy, rr_last_id, rr_res_s, rr_res_z,
                   rr_alu_a, rr_alu_b, rr_alu_aluc);
        check_inst("fp", 1, fp_r0_done, fp_r1_done, fp_busy, fp_last_id, fp_res_s, fp_res_z,
                   fp_alu_a, fp_alu_b, fp_alu_aluc);
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    // ---------------- Driver tasks ----------------------------------------
    task automatic set_r0(logic req, logic [31:0] a, logic [31:0] b, logic [3:0] c);
        r0_req = req; r0_a = a; r0_b = b; r0_aluc = c;
    endtask

    task automatic set_r1(logic req, logic [31:0] a, logic [31:0] b, logic [3:0] c);
        r1_req = req; r1_a = a; r1_b = b; r1_aluc = c;
    endtask

    task automatic do_reset(int cycles);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic rand_ops(int id);
        logic [31:0] a, b;
        logic [3:0]  c;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        c = 4'($urandom_range(0, 11));
        if (id == 0) set_r0(1'b1, a, b, c);
        else         set_r1(1'b1, a, b, c);
    endtask

    // ---------------- Stimulus --------------------------------------------
    initial begin
        set_r0(1'b0, 32'd0, 32'd0, 4'd0);
        set_r1(1'b0, 32'd0, 32'd0, 4'd0);
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("reset_last_id", 32'(rr_last_id), 32'd1);
        do_reset(2);

        // Single add on requester 0.
        set_r0(1'b1, 32'd5, 32'd3, 4'b0000);
        tick();
        check("single_early_done", 32'(rr_r0_done), 32'd0);
        tick();
        check("single_done", 32'(rr_r0_done), 32'd1);
        check("single_res_s", rr_res_s, 32'd8);
        check("single_res_z", 32'(rr_res_z), 32'd0);
        check("single_r1_done", 32'(rr_r1_done), 32'd0);
        r0_req = 1'b0;
        tick();

        // Zero flag on requester 1.
        set_r1(1'b1, 32'd7, 32'd7, 4'b0100);
        tick();
        tick();
        check("zero_done", 32'(rr_r1_done), 32'd1);
        check("zero_res_s", rr_res_s, 32'd0);
        check("zero_res_z", 32'(rr_res_z), 32'd1);
        check("zero_last_id", 32'(rr_last_id), 32'd1);
        r1_req = 1'b0;
        tick();
        tick();
        check("hold_res_z", 32'(rr_res_z), 32'd1);

        // Both held from reset: alternation (rr) and r0 monopoly (fp).
        set_r0(1'b1, 32'd1, 32'd2, 4'd0);
        set_r1(1'b1, 32'd10, 32'd4, 4'd4);
        do_reset(2);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("cont_busy", 32'(rr_busy), 32'd1);
            check("cont_fp_r1", 32'(fp_r1_done), 32'd0);
            if (i % 2 == 0) begin
                check("cont_order_r0", 32'(rr_r0_done), 32'((i / 2) % 2 == 1));
                check("cont_order_r1", 32'(rr_r1_done), 32'((i / 2) % 2 == 0));
                check("cont_fp_r0", 32'(fp_r0_done), 32'd1);
            end else begin
                check("cont_gap", 32'(rr_r0_done | rr_r1_done), 32'd0);
            end
        end
        r0_req = 1'b0;
        tick();
        tick();
        check("fp_r1_served", 32'(fp_r1_done), 32'd1);
        r1_req = 1'b0;
        tick();
        tick();

        // Operand isolation: b changes after grant.
        set_r0(1'b1, 32'($urandom), 32'h0000ABCD, 4'b0110);
        tick();
        r0_b = 32'hFFFF0000;
        tick();
        check("iso_res_rr", rr_res_s, 32'hABCD0000);
        check("iso_res_fp", fp_res_s, 32'hABCD0000);
        r0_req = 1'b0;
        tick();

        // Reset in the middle of EXEC.
        set_r0(1'b1, 32'd3, 32'd4, 4'd0);
        tick();
        #2;
        reset = 1'b1;
        r0_req = 1'b0;
        model_reset();
        #1;
        check("abort_busy", 32'(rr_busy), 32'd0);
        check("abort_res_s", rr_res_s, 32'd0);
        check("abort_done", 32'(rr_r0_done | fp_r0_done), 32'd0);
        check_all();
        tick();
        reset = 1'b0;
        set_r1(1'b1, 32'd9, 32'd1, 4'd4);
        tick();
        tick();
        check("after_abort_done", 32'(rr_r1_done), 32'd1);
        check("after_abort_res", rr_res_s, 32'd8);
        r1_req = 1'b0;
        tick();

        // Randomized traffic, including drops, operand churn and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1);
            end else begin
                for (int id = 0; id < 2; id++) begin
                    logic rq;
                    rq = (id == 0) ? r0_req : r1_req;
                    if (rq) begin
                        if ($urandom_range(0, 99) < 30) begin
                            if (id == 0) r0_req = 1'b0; else r1_req = 1'b0;
                        end else if ($urandom_range(0, 99) < 15) begin
                            rand_ops(id);
                        end
                    end else if ($urandom_range(0, 99) < 50) begin
                        rand_ops(id);
                    end
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
